fifo_rd_streamer: RTL and testbench
===================================

Name: fifo_rd_streamer

Overview:
- Read-side master for the team's synchronous FIFO (syncfifo).
- Drives the FIFO's read_en, absorbs its one-cycle registered read latency, and presents the words downstream as a lossless valid/ready stream at up to one word per clock.
- Groups the outgoing words into fixed-length bursts, flags the last word of each burst, and counts completed bursts.

Parameters:
DATA_W, 8, width of FIFO read data and stream data
BURST_LEN, 4, words per burst; legal range 2..256; m_last marks word BURST_LEN-1
CNT_W, 16, width of the completed-burst counter

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  when low, no new FIFO reads are issued; in-flight and buffered words still drain
fifo_empty  input  1  FIFO empty flag
fifo_out  input  DATA_W  FIFO registered read data; valid the cycle after fifo_read_en is high
fifo_read_en  output  1  FIFO read strobe
m_valid  output  1  stream word valid
m_ready  input  1  downstream accept
m_data  output  DATA_W  stream word
m_last  output  1  high with the final word of each burst
burst_count  output  CNT_W  number of completed bursts; wraps modulo 2^CNT_W

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- While reset is high:
  - fifo_read_en = 0 (combinational gate).
  - At the edge: m_valid = 0, m_data = 0, m_last = 0, burst_count = 0, beat counter = 0, in-flight flag = 0, skid buffer emptied.
  - Reset mid-operation discards buffered and in-flight words; a FIFO read issued in that cycle is lost and is not recovered.
- Storage and occupancy:
  - 2-entry skid buffer, order preserving; head entry drives m_data.
  - inflight = registered copy of fifo_read_en.
  - occ = buf_cnt + inflight, range 0..2.
  - pop = m_valid & m_ready.
- Read issue: fifo_read_en = ~reset & enable & ~fifo_empty & ((occ - pop) < 2). A read is never issued while fifo_empty = 1.
- Capture: if inflight = 1, fifo_out is written into the buffer tail at that edge.
- Latency:
  - fifo_read_en high in cycle N -> fifo_out valid in cycle N+1 -> m_valid high in cycle N+2 (2-cycle read-to-valid latency).
  - Write and pop in the same cycle is legal; buf_cnt is unchanged.
- Throughput: with m_ready held high and the FIFO non-empty, steady state is one word per cycle with no bubbles.
- Stream rules:
  - m_valid = (buf_cnt != 0).
  - m_data and m_last hold stable while m_valid & ~m_ready.
  - m_valid never drops without a pop.
  - Backpressure: when m_ready is low, at most 2 words are buffered/in flight and fifo_read_en falls to 0.
- Beat counter (0..BURST_LEN-1):
  - Increments on pop; wraps to 0 after BURST_LEN-1.
  - m_last = m_valid & (beat == BURST_LEN-1).
  - burst_count increments on a pop with m_last = 1; wraps at 2^CNT_W-1 -> 0.
- Empty boundary: if fifo_empty rises, no new read is issued. Buffered words still drain, and the burst resumes mid-count when data returns (the beat counter is not reset).
- enable low: in-flight words are captured and buffered words drain; the beat counter holds otherwise.
- The block does not track the FIFO's full flag; the writer side owns it.

Test Plan:
- Reset: hold reset 2 cycles with fifo_empty = 0 -> fifo_read_en = 0, m_valid = 0, m_data = 0, burst_count = 0.
- Streaming: FIFO preloaded with 0x11..0x18, m_ready = 1, enable = 1 -> first m_valid 2 cycles after the first fifo_read_en; 8 consecutive words 0x11..0x18 with no bubbles; m_last on 0x14 and 0x18; burst_count = 2.
- Backpressure: m_ready = 0 after 1 word -> fifo_read_en drops within 2 cycles; exactly 2 words buffered; m_data holds. On m_ready = 1, the order 0x12, 0x13, ... continues with no loss or duplicates.
- Empty boundary: FIFO holds 3 words, then fifo_empty = 1 for 5 cycles, then 5 more words -> no read strobes while empty; m_last on the 4th word overall.
- Wrap: CNT_W = 2, 5 bursts -> burst_count sequence 1, 2, 3, 0, 1.
- Mid-operation reset: reset asserted with 2 words buffered -> next cycle m_valid = 0 and beat = 0; after release, streaming restarts from the current FIFO head.

Source files
------------

// File: rtl/fifo_rd_streamer.sv
// Read-side master for syncfifo: issues read strobes, absorbs the one-cycle read latency
// in a 2-entry skid buffer and emits a lossless valid/ready stream framed into fixed bursts.
module fifo_rd_streamer #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_out,
    output logic              fifo_read_en,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [CNT_W-1:0]  burst_count,
    output logic [1:0]        dbg_buf_cnt_o,
    output logic              dbg_inflight_o,
    output logic [7:0]        dbg_beat_o
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [1:0]        buf_cnt_q, buf_cnt_d;
    logic              inflight_q;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0]  burst_count_q, burst_count_d;

    logic [1:0] occ;
    logic [1:0] occ_after_pop;
    logic       pop;
    logic       push;

    // Stream handshake: a word transfers on every clock where m_valid and m_ready are both
    // high; once m_valid rises it, m_data and m_last stay put until that transfer happens.
    assign m_valid = (buf_cnt_q != 2'd0);
    assign m_data  = head_q;
    assign m_last  = m_valid & (beat_q == LAST_BEAT);
    assign pop     = m_valid & m_ready;
    assign push    = inflight_q;

    // Words already read but not yet handed off: a read is allowed only if its word will
    // still find a free buffer slot when it lands one cycle later.
    assign occ           = buf_cnt_q + {1'b0, inflight_q};
    assign occ_after_pop = occ - {1'b0, pop};
    assign fifo_read_en  = ~reset & enable & ~fifo_empty & (occ_after_pop < 2'd2);

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        buf_cnt_d = buf_cnt_q;
        case ({push, pop})
            2'b10: begin
                if (buf_cnt_q == 2'd0) begin
                    head_d = fifo_out;
                end else begin
                    tail_d = fifo_out;
                end
                buf_cnt_d = buf_cnt_q + 2'd1;
            end
            2'b01: begin
                head_d    = tail_q;
                buf_cnt_d = buf_cnt_q - 2'd1;
            end
            2'b11: begin
                // Simultaneous capture and hand-off keeps the count; the new word goes behind
                // whatever remains.
                if (buf_cnt_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = fifo_out;
                end else begin
                    head_d = fifo_out;
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        beat_d        = beat_q;
        burst_count_d = burst_count_q;
        if (pop) begin
            beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
            if (m_last) begin
                burst_count_d = burst_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q        <= '0;
            tail_q        <= '0;
            buf_cnt_q     <= 2'd0;
            inflight_q    <= 1'b0;
            beat_q        <= '0;
            burst_count_q <= '0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            buf_cnt_q     <= buf_cnt_d;
            inflight_q    <= fifo_read_en;
            beat_q        <= beat_d;
            burst_count_q <= burst_count_d;
        end
    end

    assign burst_count    = burst_count_q;
    assign dbg_buf_cnt_o  = buf_cnt_q;
    assign dbg_inflight_o = inflight_q;
    assign dbg_beat_o     = 8'(beat_q);

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Bench for fifo_rd_streamer: a queue-based FIFO model feeds the DUT, and a scoreboard checks
// every accepted stream word, burst framing and the burst counter.
module tb_fifo_rd_streamer;

    localparam int DATA_W    = 8;
    localparam int BURST_LEN = 4;
    localparam int CNT_W     = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b1;
    logic              fifo_empty = 1'b1;
    logic [DATA_W-1:0] fifo_out = '0;
    logic              fifo_read_en;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic [CNT_W-1:0]  burst_count;
    logic [1:0]        dbg_buf_cnt;
    logic              dbg_inflight;
    logic [7:0]        dbg_beat;

    logic              force_empty = 1'b0;
    logic [DATA_W-1:0] fifo_mem[$];
    logic [DATA_W-1:0] exp_q[$];

    int checks = 0;
    int errors = 0;
    int mdl_beat = 0;
    int mdl_bc = 0;

    fifo_rd_streamer #(
        .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_out(fifo_out), .fifo_read_en(fifo_read_en), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .burst_count(burst_count),
        .dbg_buf_cnt_o(dbg_buf_cnt), .dbg_inflight_o(dbg_inflight), .dbg_beat_o(dbg_beat)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // FIFO model: registered read data, flag recomputed mid-cycle
    always @(posedge clk) begin
        if (fifo_read_en) begin
            if (fifo_mem.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL fifo_underflow read strobe on an empty FIFO at %0t", $time);
            end else begin
                fifo_out <= fifo_mem.pop_front();
            end
        end
    end

    always @(negedge clk) begin
        #2;
        fifo_empty = force_empty || (fifo_mem.size() == 0);
    end

    // scoreboard monitor
    logic              rst_pend = 1'b0;
    logic              hold_prev = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    logic              prev_last = 1'b0;

    always @(negedge clk) begin
        #3;
        if (rst_pend) begin
            check("rst_m_valid", int'(m_valid), 0);
            check("rst_m_data", int'(m_data), 0);
            check("rst_m_last", int'(m_last), 0);
            check("rst_burst_count", int'(burst_count), 0);
            check("rst_beat", int'(dbg_beat), 0);
            mdl_bc   = 0;
            mdl_beat = 0;
            exp_q    = fifo_mem;
        end else begin
            check("burst_count", int'(burst_count), mdl_bc);
            if (hold_prev) begin
                check("hold_valid", int'(m_valid), 1);
                check("hold_data", int'(m_data), int'(prev_data));
                check("hold_last", int'(m_last), int'(prev_last));
            end
        end
        check("read_while_empty", int'(fifo_read_en & fifo_empty), 0);
        if (!reset && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_word actual=0x%0h required=none at %0t", m_data, $time);
            end else begin
                check("m_data", int'(m_data), int'(exp_q.pop_front()));
                check("m_last", int'(m_last), int'(mdl_beat == BURST_LEN - 1));
                if (mdl_beat == BURST_LEN - 1) mdl_bc = (mdl_bc + 1) % (1 << CNT_W);
                mdl_beat = (mdl_beat + 1) % BURST_LEN;
            end
        end
        hold_prev = !reset && m_valid && !m_ready;
        prev_data = m_data;
        prev_last = m_last;
        rst_pend  = reset;
    end

    // driver tasks
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        fifo_mem.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic wait_valid(input string name);
        int seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            tick();
            #3;
            if (m_valid) seen = 1;
        end
        check(name, seen, 1);
    endtask

    task automatic wait_drain(input string name);
        int done = 0;
        for (int i = 0; i < 80 && done == 0; i++) begin
            tick();
            #3;
            if (exp_q.size() == 0 && !m_valid && !dbg_inflight) done = 1;
        end
        check(name, done, 1);
    endtask

    // stimulus
    int bc_hist[$];
    int exp_seq[5] = '{1, 2, 3, 0, 1};

    initial begin
        for (int i = 0; i < 8; i++) push_word(8'(8'h11 + i));

        // reset held two cycles with data in the FIFO
        repeat (2) begin
            tick();
            #3;
            check("rst_read_en", int'(fifo_read_en), 0);
            check("rst_valid", int'(m_valid), 0);
            check("rst_data", int'(m_data), 0);
            check("rst_bc", int'(burst_count), 0);
        end

        // streaming: read in cycle N, valid in N+2, then 8 words with no bubbles
        tick();
        reset = 1'b0;
        #3;
        check("first_read_en", int'(fifo_read_en), 1);
        check("lat_valid_n", int'(m_valid), 0);
        tick();
        #3;
        check("lat_valid_n1", int'(m_valid), 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            #3;
            check("no_bubble", int'(m_valid), 1);
        end
        tick();
        #3;
        check("stream_bc", int'(burst_count), 2);
        check("stream_drained", int'(m_valid), 0);

        // backpressure after one word
        tick();
        for (int i = 0; i < 8; i++) push_word(8'(8'h11 + i));
        wait_valid("bp_first_valid");
        tick();
        m_ready = 1'b0;
        #3;
        check("bp_read_en_off", int'(fifo_read_en), 0);
        repeat (5) begin
            tick();
            #3;
            check("bp_read_en", int'(fifo_read_en), 0);
            check("bp_data_hold", int'(m_data), 8'h12);
        end
        check("bp_buffered", int'(dbg_buf_cnt), 2);
        check("bp_inflight", int'(dbg_inflight), 0);
        tick();
        m_ready = 1'b1;
        wait_drain("bp_drain");
        check("bp_bc", int'(burst_count), 0);

        // empty boundary: 3 words, empty for 5 cycles, then 5 more
        tick();
        for (int i = 0; i < 3; i++) push_word(8'(8'h21 + i));
        wait_drain("empty_drain3");
        check("empty_beat", int'(dbg_beat), 3);
        tick();
        force_empty = 1'b1;
        for (int i = 0; i < 5; i++) push_word(8'(8'h24 + i));
        repeat (5) begin
            tick();
            #3;
            check("empty_no_read", int'(fifo_read_en), 0);
            check("empty_valid", int'(m_valid), 0);
        end
        tick();
        force_empty = 1'b0;
        wait_drain("empty_drain5");
        check("empty_bc", int'(burst_count), 2);

        // reset with two words buffered
        tick();
        for (int i = 0; i < 6; i++) push_word(8'(8'h31 + i));
        wait_valid("mid_first_valid");
        tick();
        m_ready = 1'b0;
        begin
            int full = 0;
            for (int i = 0; i < 10 && full == 0; i++) begin
                tick();
                #3;
                if (dbg_buf_cnt == 2'd2) full = 1;
            end
            check("mid_buffered", full, 1);
        end
        check("mid_beat_before", int'(dbg_beat), 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #3;
        check("mid_valid", int'(m_valid), 0);
        check("mid_beat", int'(dbg_beat), 0);
        check("mid_bc", int'(burst_count), 0);
        m_ready = 1'b1;
        wait_drain("mid_drain");

        // randomized 5-burst run through the 2-bit counter wrap
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        begin
            int pushed = 0;
            int done = 0;
            int last_bc = 0;
            for (int i = 0; i < 800 && done == 0; i++) begin
                tick();
                m_ready     = ($urandom_range(0, 3) != 0);
                enable      = ($urandom_range(0, 3) != 0);
                force_empty = ($urandom_range(0, 7) == 0);
                if (pushed < 20 && $urandom_range(0, 2) != 0) begin
                    push_word(8'($urandom_range(0, 255)));
                    pushed++;
                end
                #3;
                if (int'(burst_count) != last_bc) begin
                    last_bc = int'(burst_count);
                    bc_hist.push_back(last_bc);
                end
                if (pushed == 20 && exp_q.size() == 0 && !m_valid && !dbg_inflight) done = 1;
            end
            check("wrap_done", done, 1);
        end
        m_ready = 1'b1;
        enable = 1'b1;
        force_empty = 1'b0;
        check("wrap_len", bc_hist.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check("wrap_seq", (i < bc_hist.size()) ? bc_hist[i] : -1, exp_seq[i]);
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
